// File: rtl/mux_4x_arbiter_if.sv
// Handshake and data bundle between four requesters, the arbiter and its downstream consumer.
// The master modport is the arbiter side; slave is the requester/consumer side.
interface mux_4x_arbiter_if #(
  parameter int unsigned BUS_WIDTH = 8
);
  logic [3:0]           req;
  logic [BUS_WIDTH-1:0] a;
  logic [BUS_WIDTH-1:0] b;
  logic [BUS_WIDTH-1:0] c;
  logic [BUS_WIDTH-1:0] d;
  logic [3:0]           grant;
  logic [1:0]           sel;
  logic [BUS_WIDTH-1:0] y_data;
  logic                 y_valid;
  logic                 y_ready;

  modport master (
    input  req, a, b, c, d, y_ready,
    output grant, sel, y_data, y_valid
  );

  modport slave (
    output req, a, b, c, d, y_ready,
    input  grant, sel, y_data, y_valid
  );
endinterface

// File: rtl/mux_4x_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux path; registers the winning word for a valid/ready sink.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no rotating pointer).
module mux_4x_arbiter #(
  parameter int unsigned BUS_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  mux_4x_arbiter_if.master bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [BUS_WIDTH-1:0] y_data_q, y_data_d;
  logic                 y_valid_q, y_valid_d;
  logic [3:0]           grant_q, grant_d;
  logic [1:0]           win;
  logic [BUS_WIDTH-1:0] win_data;

`ifdef MUX_ARB_FIXED_PRIO_EN
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win = 2'(i);
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;

  // Scan from the farthest offset down so the first hit after ptr wins.
  always_comb begin
    logic [1:0] idx;
    win = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (bus.req[idx]) win = idx;
    end
  end
`endif

  always_comb begin
    win_data = bus.a;
    unique case (win)
      2'd0: win_data = bus.a;
      2'd1: win_data = bus.b;
      2'd2: win_data = bus.c;
      2'd3: win_data = bus.d;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    y_data_d  = y_data_q;
    y_valid_d = y_valid_q;
    grant_d   = 4'b0000;
`ifndef MUX_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.req != 4'b0000) begin
          sel_d     = win;
          y_data_d  = win_data;
          y_valid_d = 1'b1;
          grant_d   = 4'b0001 << win;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // Transfer always drops back to idle, leaving a deliberate one-cycle bubble.
        if (bus.y_ready) begin
          y_valid_d = 1'b0;
          state_d   = StIdle;
`ifndef MUX_ARB_FIXED_PRIO_EN
          ptr_d     = sel_q + 2'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= 2'd0;
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      grant_q   <= 4'b0000;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q     <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      y_data_q  <= y_data_d;
      y_valid_q <= y_valid_d;
      grant_q   <= grant_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.y_data  = y_data_q;
  assign bus.y_valid = y_valid_q;

endmodule

// File: tb/tb_mux_4x_arbiter.sv
// Directed and randomized bench for mux_4x_arbiter against a cycle-level transaction model.
// Honours MUX_ARB_FIXED_PRIO_EN for the expected arbitration order.
module tb_mux_4x_arbiter;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  mux_4x_arbiter_if #(.BUS_WIDTH(W)) bus ();

  mux_4x_arbiter #(.BUS_WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a held word, who owns it, and whose turn is next.
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  int           m_ptr;
  logic [3:0]   m_grant;

  function automatic int pick(logic [3:0] r, int p);
    int s;
    for (int k = 0; k < 4; k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
      s = k;
`else
      s = (p + k) % 4;
`endif
      if (r[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [W-1:0] src [4];
    int w;
    src[0] = bus.a; src[1] = bus.b; src[2] = bus.c; src[3] = bus.d;
    m_grant = 4'b0000;
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid) begin
      w = pick(bus.req, m_ptr);
      if (w >= 0) begin
        m_sel = w; m_data = src[w]; m_valid = 1'b1; m_grant[w] = 1'b1;
      end
    end else if (bus.y_ready) begin
      m_valid = 1'b0;
      m_ptr = (m_sel + 1) % 4;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".y_valid"}, 32'(bus.y_valid), 32'(m_valid));
    chk({tag, ".y_data"},  32'(bus.y_data),  32'(m_data));
    chk({tag, ".sel"},     32'(bus.sel),     32'(m_sel));
    chk({tag, ".grant"},   32'(bus.grant),   32'(m_grant));
  endtask

  // Inputs are changed only after a negedge; the DUT samples them at the following posedge.
  task automatic step(string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step("reset");
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_seq [5];
    int n;

    bus.req = 4'b0000; bus.y_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; m_grant = 4'b0000;

    // Idle after reset.
    reset = 1'b1;
    step("rst0");
    step("rst1");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("idle");
      chk("idle.y_valid_const", 32'(bus.y_valid), 32'd0);
    end

    // Single request from source 2.
    bus.req = 4'b0100; bus.c = 8'hA5; bus.y_ready = 1'b1;
    step("single");
    chk("single.sel",   32'(bus.sel),    32'd2);
    chk("single.data",  32'(bus.y_data), 32'hA5);
    chk("single.grant", 32'(bus.grant),  32'b0100);
    bus.req = 4'b0000;
    step("single_xfer");
    chk("single.drop", 32'(bus.y_valid), 32'd0);

    // All four requesting continuously.
    do_reset();
    bus.req = 4'b1111; bus.a = 8'h11; bus.b = 8'h22; bus.c = 8'h33; bus.d = 8'h44;
    bus.y_ready = 1'b1;
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_seq = '{8'h11, 8'h11, 8'h11, 8'h11, 8'h11};
`else
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
`endif
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step("all4");
      if (m_grant != 4'b0000 && n < 5) begin
        chk("all4.order", 32'(bus.y_data), 32'(exp_seq[n]));
        n++;
      end
    end
    chk("all4.count", 32'(n), 32'd5);

    // Backpressure while requests change underneath.
    do_reset();
    bus.req = 4'b0010; bus.b = 8'h5A; bus.y_ready = 1'b0;
    step("bp_grant");
    bus.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step("bp_hold");
      chk("bp.valid", 32'(bus.y_valid), 32'd1);
      chk("bp.sel",   32'(bus.sel),     32'd1);
      chk("bp.data",  32'(bus.y_data),  32'h5A);
    end
    bus.y_ready = 1'b1;
    step("bp_xfer");
    step("bp_next");
`ifdef MUX_ARB_FIXED_PRIO_EN
    chk("bp.next_grant", 32'(bus.grant), 32'b0001);
`else
    chk("bp.next_grant", 32'(bus.grant), 32'b1000);
`endif

    // Pointer wrap after source 3.
    step("wrap_xfer");
    bus.req = 4'b0011;
    step("wrap");
    chk("wrap.grant", 32'(bus.grant), 32'b0001);

    // Reset in the middle of a held word.
    do_reset();
    bus.req = 4'b0100; bus.y_ready = 1'b0;
    step("mid_busy");
    reset = 1'b1;
    step("mid_rst");
    chk("mid_rst.valid", 32'(bus.y_valid), 32'd0);
    chk("mid_rst.grant", 32'(bus.grant),   32'd0);
    reset = 1'b0;
    bus.req = 4'b1110;
    step("post_rst");
    chk("post_rst.grant", 32'(bus.grant), 32'b0010);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req     = 4'($urandom_range(0, 15));
      bus.a       = W'($urandom);
      bus.b       = W'($urandom);
      bus.c       = W'($urandom);
      bus.d       = W'($urandom);
      bus.y_ready = 1'($urandom_range(0, 1));
      reset       = ($urandom_range(0, 31) == 0);
      step("rand");
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_4x_arbiter.md
Name: mux_4x_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one 4:1 BUS_WIDTH-bit mux path (inputs a/b/c/d, select sel) between four requesters.
- Picks one requester, drives sel, registers the selected word, and presents it downstream on a valid/ready handshake.
- Sits directly in front of the mux_4x_nbit datapath; the sel output drives that mux.

Parameters:
- BUS_WIDTH, 8, width of each data input and of y_data.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset, sampled on rising clk.
- req  input  4  request per source; req[0]=a, req[1]=b, req[2]=c, req[3]=d; level-held until granted.
- a  input  BUS_WIDTH  source 0 data, valid while req[0]=1.
- b  input  BUS_WIDTH  source 1 data.
- c  input  BUS_WIDTH  source 2 data.
- d  input  BUS_WIDTH  source 3 data.
- grant  output  4  one-hot, one-cycle pulse: the requester's word has been captured and it may drop or change req.
- sel  output  2  registered select of the winning source (0..3); drives the mux select.
- y_data  output  BUS_WIDTH  registered selected word.
- y_valid  output  1  y_data holds an unaccepted word.
- y_ready  input  1  downstream accepts y_data when y_valid=1 and y_ready=1.

Behaviour:
- Reset values: state=IDLE, y_valid=0, y_data=0, sel=0, grant=0, priority pointer ptr=0 (source 0 highest).
- FSM states:
  - IDLE: no word held.
  - BUSY: word held, waiting for accept.
- IDLE with req==0: stay in IDLE; outputs are unchanged except grant=0.
- IDLE with req!=0:
  - Winner w = first set bit of req, searched circularly from ptr: ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - Next edge: sel<=w, y_data<=input w, y_valid<=1, grant<=one-hot(w) for exactly one cycle, state<=BUSY.
- Latency: req sampled high at edge N gives y_valid=1 and grant pulse visible after edge N, i.e. one cycle.
- BUSY with y_ready=0: hold sel, y_data and y_valid=1 stable; grant=0. New req changes are ignored.
- BUSY with y_ready=1 (transfer):
  - Next edge: y_valid<=0, ptr<=(sel+1) mod 4 with wrap 3->0, state<=IDLE.
  - sel and y_data keep their last values.
- Throughput: at most one word per two cycles. The transfer cycle always returns to IDLE, giving a one-cycle bubble; this is intentional.
- Fairness: with all four req held high continuously, the grant order is 0,1,2,3,0,... No source waits more than 3 other grants.
- A requester that drops req before it is granted is simply not selected; this is not an error.
- y_ready while y_valid=0 is ignored.
- A req bit still high in the cycle after its grant pulse is treated as a new request. Requesters must drop req or present new data accordingly.
- Reset asserted mid-BUSY: the held word is discarded, y_valid=0 on the next edge, ptr returns to 0, no grant issued.
- Reset has priority over all other events in the same cycle.

Optional Feature:
- Macro: MUX_ARB_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed-priority: the lowest-index set req bit wins (0 highest, 3 lowest).
  - ptr is not implemented and not updated.
  - Starvation of higher indices is permitted.
  - All ports, timing and handshake behaviour are identical to the default.
- Not defined: round-robin arbitration as described in Behaviour.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> y_valid=0, grant=0, sel=0, y_data=0 throughout.
- After reset, req=4'b0100, c=8'hA5, y_ready=1 -> one cycle later sel=2, y_data=8'hA5, y_valid=1, grant=4'b0100 for one cycle; the next cycle y_valid=0.
- req=4'b1111 held, a=8'h11, b=8'h22, c=8'h33, d=8'h44, y_ready=1 for 10 cycles:
  - Default: y_data sequence 11,22,33,44,11 on alternate cycles.
  - With MUX_ARB_FIXED_PRIO_EN: y_data is always 11.
- Backpressure: grant source 1 (b=8'h5A), hold y_ready=0 for 4 cycles while req changes to 4'b1001 -> y_valid=1, sel=1, y_data=8'h5A stable for all 4 cycles. Raising y_ready gives a transfer; the next grant goes to source 3 (ptr=2; circular search 2,3 finds bit 3).
- Wrap-around: last granted source 3, then req=4'b0011 -> source 0 wins (ptr wrapped to 0).
- Reset asserted while BUSY with y_valid=1, y_ready=0 -> the next cycle y_valid=0, state IDLE. With req=4'b1110 after reset, source 1 is granted first (ptr=0, circular search reaches bit 1).
